// File: rtl/work_shift_ctrl.sv
// Buffers one job of TOTAL_WORDS source words, then streams them to the hashing
// core in two phases that stay in lockstep with an external shift timer.
module work_shift_ctrl #(
  parameter int DATA_W      = 32,
  parameter int MID_WORDS   = 8,
  parameter int TOTAL_WORDS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              midstate_shifts_done,
  input  logic              remaining_shifts_done,
  output logic [2:0]        controller_state,
  output logic              shift_valid,
  output logic [DATA_W-1:0] shift_data,
  output logic              shift_last,
  output logic              hash_start,
  output logic              busy,
  output logic              proto_err
);

  localparam logic [2:0] S_IDLE      = 3'b000;
  localparam logic [2:0] S_MIDSTATE  = 3'b001;
  localparam logic [2:0] S_REMAINING = 3'b010;
  localparam logic [2:0] S_HASH      = 3'b011;
  localparam logic [2:0] S_LOAD      = 3'b100;

  localparam int IDX_W  = $clog2(TOTAL_WORDS) + 1;
  localparam int ADDR_W = $clog2(TOTAL_WORDS);

  localparam logic [IDX_W-1:0] MID_IDX   = IDX_W'(MID_WORDS);
  localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL_WORDS - 1);

  logic [2:0]        state;
  logic [2:0]        state_n;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic [DATA_W-1:0] buffer [TOTAL_WORDS];
  logic [DATA_W-1:0] rd_word;
  logic              xfer;
  logic              wr_en;
  logic              shift_valid_n;
  logic [DATA_W-1:0] shift_data_n;
  logic              shift_last_n;
  logic              proto_err_n;

  assign controller_state = state;

  // Source handshake: a word moves on any rising edge where in_valid and
  // in_ready are both high; in_ready is high exactly while in LOAD.
  assign xfer = in_valid && in_ready;

  // Out-of-range index reads as zero so the buffer is never addressed past its end.
  assign rd_word = (idx < TOTAL_IDX) ? buffer[idx[ADDR_W-1:0]] : '0;

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    wr_en         = 1'b0;
    shift_valid_n = 1'b0;
    shift_data_n  = '0;
    shift_last_n  = 1'b0;
    proto_err_n   = proto_err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_LOAD;
          idx_n       = '0;
          proto_err_n = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            state_n = S_MIDSTATE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_MIDSTATE: begin
        // The timer flag and the boundary index must agree in both directions.
        if (midstate_shifts_done != (idx == MID_IDX)) begin
          proto_err_n = 1'b1;
          state_n     = S_IDLE;
          idx_n       = '0;
        end else begin
          shift_valid_n = 1'b1;
          shift_data_n  = rd_word;
          idx_n         = idx + 1'b1;
          if (idx == MID_IDX) begin
            state_n = S_REMAINING;
          end
        end
      end
      S_REMAINING: begin
        if (idx == TOTAL_IDX) begin
          idx_n = '0;
          if (remaining_shifts_done) begin
            state_n = S_HASH;
          end else begin
            proto_err_n = 1'b1;
            state_n     = S_IDLE;
          end
        end else if (remaining_shifts_done) begin
          proto_err_n = 1'b1;
          state_n     = S_IDLE;
          idx_n       = '0;
        end else begin
          shift_valid_n = 1'b1;
          shift_data_n  = rd_word;
          shift_last_n  = (idx == LAST_IDX);
          idx_n         = idx + 1'b1;
        end
      end
      S_HASH: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      in_ready    <= 1'b0;
      shift_valid <= 1'b0;
      shift_data  <= '0;
      shift_last  <= 1'b0;
      hash_start  <= 1'b0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      in_ready    <= (state_n == S_LOAD);
      shift_valid <= shift_valid_n;
      shift_data  <= shift_data_n;
      shift_last  <= shift_last_n;
      hash_start  <= (state_n == S_HASH);
      busy        <= (state_n != S_IDLE);
      proto_err   <= proto_err_n;
    end
  end

  // Buffer contents survive reset; a new job simply overwrites them.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      buffer[idx[ADDR_W-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_work_shift_ctrl.sv
// Directed bench for work_shift_ctrl with a behavioural shift-timer model
// attached to controller_state.
module tb_work_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        midstate_shifts_done;
  logic        remaining_shifts_done;
  logic [2:0]  controller_state;
  logic        shift_valid;
  logic [31:0] shift_data;
  logic        shift_last;
  logic        hash_start;
  logic        busy;
  logic        proto_err;

  work_shift_ctrl #(.DATA_W(32), .MID_WORDS(8), .TOTAL_WORDS(24)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .midstate_shifts_done  (midstate_shifts_done),
    .remaining_shifts_done (remaining_shifts_done),
    .controller_state      (controller_state),
    .shift_valid           (shift_valid),
    .shift_data            (shift_data),
    .shift_last            (shift_last),
    .hash_start            (hash_start),
    .busy                  (busy),
    .proto_err             (proto_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- shift timer model ----------------
  logic [5:0] tcount;
  logic [5:0] mid_flag_at = 6'd8;
  logic [5:0] rem_flag_at = 6'd24;

  always @(posedge clk) begin
    if (rst) tcount <= '0;
    else if (controller_state == 3'b001 || controller_state == 3'b010) tcount <= tcount + 1'b1;
    else tcount <= '0;
  end
  assign midstate_shifts_done  = (tcount == mid_flag_at);
  assign remaining_shifts_done = (tcount == rem_flag_at);

  // ---------------- scoreboard state ----------------
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int load_bad, load_timeout;
  int first_t, last_valid_t, mid_cnt, rem_cnt, last_cnt, last_t;
  int hash_cnt, hash_t, busy_fall_t, err_t, ready_bad, zero_bad;
  logic [31:0] last_word;

  // ---------------- driver tasks ----------------
  task automatic start_job();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_words(input bit stall, input logic [31:0] base);
    int k = 0;
    int cyc = 0;
    bit rdy;
    load_bad = 0;
    exp_q.delete();
    while (k < 24 && cyc < 300) begin
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? base + 32'(k) : 32'hDEAD_BEEF;
      rdy = in_ready;
      if (controller_state !== 3'b100 || shift_valid !== 1'b0) load_bad++;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        exp_q.push_back(base + 32'(k));
        k++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    load_timeout = (k < 24) ? 1 : 0;
  endtask

  task automatic capture(input int start_at);
    got_q.delete();
    first_t = -1; last_valid_t = -1; mid_cnt = 0; rem_cnt = 0;
    last_cnt = 0; last_t = -1; last_word = '0; hash_cnt = 0; hash_t = -1;
    busy_fall_t = -1; err_t = -1; ready_bad = 0; zero_bad = 0;
    for (int t = 0; t < 32; t++) begin
      if (controller_state == 3'b001) mid_cnt++;
      if (controller_state == 3'b010) rem_cnt++;
      if (shift_valid) begin
        got_q.push_back(shift_data);
        if (first_t < 0) first_t = t;
        last_valid_t = t;
      end else if (shift_data !== 32'h0) zero_bad++;
      if (shift_last) begin last_cnt++; last_word = shift_data; last_t = t; end
      if (hash_start) begin hash_cnt++; if (hash_t < 0) hash_t = t; end
      if (!busy && busy_fall_t < 0) busy_fall_t = t;
      if (proto_err && err_t < 0) err_t = t;
      if (in_ready) ready_bad++;
      start = (t == start_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 0; in_valid = 0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (controller_state !== 3'b000) begin n_miss++; $display("FAIL reset_state got=%0h exp=0", controller_state); end
    n_vec++; if ({in_ready, shift_valid, shift_last, hash_start, busy, proto_err} !== 6'b0) begin
      n_miss++; $display("FAIL reset_flags got=%b exp=000000", {in_ready, shift_valid, shift_last, hash_start, busy, proto_err}); end
    n_vec++; if (shift_data !== 32'h0) begin n_miss++; $display("FAIL reset_data got=%0h exp=0", shift_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    start_job();
    n_vec++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_miss++; $display("FAIL nom_load_entry got=%b%b exp=11", busy, in_ready); end
    load_words(1'b0, 32'h1);
    n_vec++; if (load_timeout != 0 || load_bad != 0) begin n_miss++; $display("FAIL nom_load got=%0d/%0d exp=0/0", load_timeout, load_bad); end
    capture(-1);
    n_vec++; if (got_q.size() != 24) begin n_miss++; $display("FAIL nom_count got=%0d exp=24", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL nom_word%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (first_t != 1 || last_valid_t != 24) begin n_miss++; $display("FAIL nom_window got=%0d..%0d exp=1..24", first_t, last_valid_t); end
    n_vec++; if (mid_cnt != 9) begin n_miss++; $display("FAIL nom_mid_cycles got=%0d exp=9", mid_cnt); end
    n_vec++; if (rem_cnt != 16) begin n_miss++; $display("FAIL nom_rem_cycles got=%0d exp=16", rem_cnt); end
    n_vec++; if (last_cnt != 1 || last_word !== 32'h18 || last_t != 24) begin
      n_miss++; $display("FAIL nom_last got=%0d/%0h/%0d exp=1/18/24", last_cnt, last_word, last_t); end
    n_vec++; if (hash_cnt != 1 || hash_t != 25) begin n_miss++; $display("FAIL nom_hash got=%0d@%0d exp=1@25", hash_cnt, hash_t); end
    n_vec++; if (busy_fall_t != 26) begin n_miss++; $display("FAIL nom_busy_fall got=%0d exp=26", busy_fall_t); end
    n_vec++; if (err_t != -1 || ready_bad != 0 || zero_bad != 0) begin
      n_miss++; $display("FAIL nom_side got=%0d/%0d/%0d exp=-1/0/0", err_t, ready_bad, zero_bad); end
  endtask

  task automatic test_source_stalls();
    start_job();
    load_words(1'b1, 32'h1);
    n_vec++; if (load_timeout != 0 || load_bad != 0) begin n_miss++; $display("FAIL stall_load got=%0d/%0d exp=0/0", load_timeout, load_bad); end
    capture(-1);
    n_vec++; if (got_q.size() != 24) begin n_miss++; $display("FAIL stall_count got=%0d exp=24", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL stall_word%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (mid_cnt != 9 || rem_cnt != 16 || hash_t != 25) begin
      n_miss++; $display("FAIL stall_timing got=%0d/%0d/%0d exp=9/16/25", mid_cnt, rem_cnt, hash_t); end
  endtask

  task automatic test_early_mid_flag();
    mid_flag_at = 6'd5;
    start_job();
    load_words(1'b0, 32'h1);
    capture(-1);
    n_vec++; if (got_q.size() != 5) begin n_miss++; $display("FAIL early_mid_count got=%0d exp=5", got_q.size()); end
    n_vec++; if (err_t != 6 || busy_fall_t != 6) begin n_miss++; $display("FAIL early_mid_err got=%0d/%0d exp=6/6", err_t, busy_fall_t); end
    n_vec++; if (hash_cnt != 0 || zero_bad != 0) begin n_miss++; $display("FAIL early_mid_hash got=%0d/%0d exp=0/0", hash_cnt, zero_bad); end
    n_vec++; if (controller_state !== 3'b000 || proto_err !== 1'b1) begin
      n_miss++; $display("FAIL early_mid_sticky got=%0h/%b exp=0/1", controller_state, proto_err); end
    mid_flag_at = 6'd8;
    start_job();
    n_vec++; if (proto_err !== 1'b0 || controller_state !== 3'b100) begin
      n_miss++; $display("FAIL err_clear got=%b/%0h exp=0/4", proto_err, controller_state); end
    load_words(1'b0, 32'h55);
    capture(-1);
    n_vec++; if (hash_cnt != 1 || err_t != -1 || got_q.size() != 24) begin
      n_miss++; $display("FAIL err_recover got=%0d/%0d/%0d exp=1/-1/24", hash_cnt, err_t, got_q.size()); end
  endtask

  task automatic test_missing_mid_flag();
    mid_flag_at = 6'd63;
    start_job();
    load_words(1'b0, 32'h1);
    capture(-1);
    n_vec++; if (got_q.size() != 8 || err_t != 9) begin
      n_miss++; $display("FAIL late_mid got=%0d/%0d exp=8/9", got_q.size(), err_t); end
    n_vec++; if (hash_cnt != 0) begin n_miss++; $display("FAIL late_mid_hash got=%0d exp=0", hash_cnt); end
    mid_flag_at = 6'd8;
  endtask

  task automatic test_missing_rem_flag();
    rem_flag_at = 6'd63;
    start_job();
    load_words(1'b0, 32'h1);
    capture(-1);
    n_vec++; if (got_q.size() != 24 || last_word !== 32'h18) begin
      n_miss++; $display("FAIL no_rem_words got=%0d/%0h exp=24/18", got_q.size(), last_word); end
    n_vec++; if (err_t != 25 || busy_fall_t != 25 || hash_cnt != 0) begin
      n_miss++; $display("FAIL no_rem_err got=%0d/%0d/%0d exp=25/25/0", err_t, busy_fall_t, hash_cnt); end
    rem_flag_at = 6'd24;
  endtask

  task automatic test_early_rem_flag();
    rem_flag_at = 6'd15;
    start_job();
    load_words(1'b0, 32'h1);
    capture(-1);
    n_vec++; if (got_q.size() != 15 || err_t != 16 || hash_cnt != 0) begin
      n_miss++; $display("FAIL early_rem got=%0d/%0d/%0d exp=15/16/0", got_q.size(), err_t, hash_cnt); end
    rem_flag_at = 6'd24;
  endtask

  task automatic test_reset_mid_shift();
    start_job();
    load_words(1'b0, 32'h100);
    for (int t = 0; t < 12; t++) begin @(posedge clk); #1; end
    n_vec++; if (controller_state !== 3'b010) begin n_miss++; $display("FAIL rst_pre_state got=%0h exp=2", controller_state); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (controller_state !== 3'b000 || shift_data !== 32'h0) begin
      n_miss++; $display("FAIL rst_mid_state got=%0h/%0h exp=0/0", controller_state, shift_data); end
    n_vec++; if ({in_ready, shift_valid, shift_last, hash_start, busy, proto_err} !== 6'b0) begin
      n_miss++; $display("FAIL rst_mid_flags got=%b exp=000000", {in_ready, shift_valid, shift_last, hash_start, busy, proto_err}); end
    rst = 1'b0;
    @(posedge clk); #1;
    start_job();
    load_words(1'b0, 32'hA5A5_0000);
    capture(-1);
    n_vec++; if (got_q.size() != 24 || hash_t != 25) begin
      n_miss++; $display("FAIL rst_resume got=%0d/%0d exp=24/25", got_q.size(), hash_t); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL rst_resume_word%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    start_job();
    load_words(1'b0, 32'h1);
    capture(3);
    n_vec++; if (got_q.size() != 24 || first_t != 1 || last_valid_t != 24) begin
      n_miss++; $display("FAIL busy_start_window got=%0d/%0d/%0d exp=24/1/24", got_q.size(), first_t, last_valid_t); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL busy_start_word%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (mid_cnt != 9 || rem_cnt != 16 || hash_t != 25 || busy_fall_t != 26) begin
      n_miss++; $display("FAIL busy_start_timing got=%0d/%0d/%0d/%0d exp=9/16/25/26", mid_cnt, rem_cnt, hash_t, busy_fall_t); end
    n_vec++; if (controller_state !== 3'b000) begin n_miss++; $display("FAIL busy_start_idle got=%0h exp=0", controller_state); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_source_stalls();
    test_early_mid_flag();
    test_missing_mid_flag();
    test_missing_rem_flag();
    test_early_rem_flag();
    test_reset_mid_shift();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/work_shift_ctrl.md
WORK_SHIFT_CTRL -- requirements
Module: work_shift_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, word width; MID_WORDS, 8, midstate words; TOTAL_WORDS, 24, midstate plus remaining words.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 start  in  1  request new job; honoured only in IDLE.
REQ-005 in_valid / in_ready / in_data  in / out / DATA_W  source word handshake; transfer when in_valid and in_ready are both high.
REQ-006 midstate_shifts_done  in  1  shift-timer flag; high when the timer count equals MID_WORDS.
REQ-007 remaining_shifts_done  in  1  shift-timer flag; high when the timer count equals TOTAL_WORDS.
REQ-008 controller_state  out  3  phase code driving the shift timer.
REQ-009 shift_valid / shift_data / shift_last  out / out / out  1 / DATA_W / 1  word presented to the hashing core this cycle.
REQ-010 hash_start  out  1  one-cycle pulse when all words are shifted.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 proto_err  out  1  sticky flag: timer and internal index disagree.

Function
REQ-013 States and controller_state codes SHALL be: IDLE=000, MIDSTATE=001, REMAINING=010, HASH=011, LOAD=100; no other codes are driven.
REQ-014 IDLE: start=1 -> LOAD, proto_err cleared, word index idx cleared; start is ignored in every other state.
REQ-015 LOAD: in_ready=1; each transfer stores in_data into buffer[idx] and increments idx; the transfer that brings idx to TOTAL_WORDS leads to MIDSTATE next cycle, with idx reset to 0.
REQ-016 Once buffering completes, in_ready SHALL be 0, and shifting SHALL NOT stall: one word per cycle in MIDSTATE and REMAINING, in lockstep with the external timer.
REQ-017 MIDSTATE: shift_valid=1, shift_data=buffer[idx], idx++ every cycle.
REQ-018 MIDSTATE with midstate_shifts_done=1 and idx==MID_WORDS -> REMAINING; that cycle SHALL still shift buffer[MID_WORDS], so there is no gap between phases.
REQ-019 MIDSTATE with the done flag and idx mismatched, in either direction (flag early, or idx==MID_WORDS without the flag), SHALL raise proto_err, drive shift_valid=0 that cycle, and go to IDLE.
REQ-020 REMAINING: shift words while idx<TOTAL_WORDS; shift_last=1 with word TOTAL_WORDS-1.
REQ-021 REMAINING at idx==TOTAL_WORDS: shift_valid=0; if remaining_shifts_done=1 -> HASH, otherwise proto_err and IDLE; remaining_shifts_done=1 at any earlier idx also raises proto_err and goes to IDLE.
REQ-022 HASH: hash_start=1 for exactly one cycle, then IDLE; a full job therefore takes 24 load transfers + 25 shift-phase cycles + 1 HASH cycle.
REQ-023 idx SHALL be $clog2(TOTAL_WORDS)+1 bits wide and SHALL never wrap; buffer addresses are always < TOTAL_WORDS.
REQ-024 shift_data SHALL be 0 whenever shift_valid=0.
REQ-025 Outputs SHALL be registered, except controller_state, which is the registered state itself.

Reset
REQ-026 rst=1 at any point, including mid-LOAD or mid-shift, SHALL within one edge force: state IDLE (controller_state=000, which clears the timer), idx=0, in_ready=0, shift_valid=0, shift_last=0, shift_data=0, hash_start=0, busy=0, proto_err=0.
REQ-027 Buffer contents are not reset; a partially loaded job is discarded.

Verification
REQ-028 Nominal: start, then 24 words 0x00000001..0x00000018 with the timer model attached -> shift_data 0x01..0x18 on 24 consecutive cycles; controller_state 001 for 9 cycles, then 010 for 16; shift_last with 0x18; hash_start one cycle after; busy falls next cycle.
REQ-029 Source stalls: in_valid toggled randomly during LOAD -> identical shift sequence, no shift during LOAD, and controller_state=100 throughout LOAD.
REQ-030 Early midstate flag: force midstate_shifts_done=1 at idx=5 -> proto_err=1, state IDLE next cycle, no hash_start; the next start clears proto_err.
REQ-031 Missing remaining flag: hold remaining_shifts_done=0 -> at idx=24, proto_err=1 and IDLE, no hash_start.
REQ-032 Reset mid-shift: assert rst at REMAINING idx=12 -> all outputs at reset values after one edge; a fresh job then completes normally.
REQ-033 start during busy: pulse start in MIDSTATE -> ignored; the sequence is unchanged.
